// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: turns a MAC TX byte stream into a GMII transmit frame.
// Adds preamble/SFD, enforces the inter-frame gap and flags underruns.
// Optional feature macro GMII_TX_CRC_EN: short-frame padding plus CRC-32 FCS.
// Without it the source supplies the complete frame (FCS included).
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
) (
    input  logic       TxClk,
    input  logic       rst,
    input  logic       ClkEN,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    input  logic       s_err,
    output logic       s_ready,
    output logic [7:0] TxD,
    output logic       TxEn,
    output logic       TxErr,
    output logic       tx_busy,
    output logic       underrun
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SFD  = 3'd2,
        DATA = 3'd3,
        PAD  = 3'd4,
        FCS  = 3'd5,
        IFG  = 3'd6
    } state_t;

    // Counter wide enough to hold IFG_BYTES plus one without wrapping.
    localparam int            IW       = $clog2(IFG_BYTES + 2);
    localparam logic [7:0]    PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [IW-1:0] IFG_N    = IW'(IFG_BYTES);

    state_t        state, state_n;
    logic [7:0]    seq_cnt, seq_n;      // preamble bytes sent, then FCS byte index
    logic [IW-1:0] ifg_cnt, ifg_n;      // TxEn-low byte cycles since the frame ended
    logic [7:0]    txd_n;
    logic          txen_n, txerr_n, urun_n;
    logic          ifg_ok;

`ifdef GMII_TX_CRC_EN
    localparam logic [15:0] MIN_F = 16'(MIN_FRAME);

    // Only the padding decision consumes the byte count.
    logic [15:0] byte_cnt, byte_n, byte_inc;
    logic [31:0] crc, crc_n, fcs;

    // Reflected CRC-32 (0x04C11DB7 -> 0xEDB88320), one byte LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign byte_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    assign fcs      = ~crc;
`endif

    assign ifg_ok  = (ifg_cnt >= IFG_N);
    assign s_ready = (state == DATA) & ClkEN;
    assign tx_busy = (state != IDLE);

    // State register: reset wins, otherwise advance only on byte cycles.
    always_ff @(posedge TxClk) begin
        if (!rst)
            state <= IDLE;
        else if (ClkEN)
            state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (s_valid && ifg_ok) state_n = (PRE_LAST == 8'd0) ? SFD : PRE;
            PRE:  if (seq_cnt >= PRE_LAST) state_n = SFD;
            SFD:  state_n = DATA;
            DATA: begin
                if (!s_valid)
                    state_n = IFG;
                else if (s_last) begin
`ifdef GMII_TX_CRC_EN
                    state_n = (byte_inc < MIN_F) ? PAD : FCS;
`else
                    state_n = IFG;
`endif
                end
            end
`ifdef GMII_TX_CRC_EN
            PAD:  if (byte_inc >= MIN_F) state_n = FCS;
            FCS:  if (seq_cnt[1:0] == 2'd3) state_n = IFG;
`endif
            IFG:  if ((ifg_cnt + 1'b1) >= IFG_N) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output and counter next values; outputs show what the coming edge loads.
    always_comb begin
        txd_n   = 8'h00;
        txen_n  = 1'b0;
        txerr_n = 1'b0;
        urun_n  = 1'b0;
        seq_n   = seq_cnt;
        ifg_n   = ifg_cnt;
`ifdef GMII_TX_CRC_EN
        byte_n  = byte_cnt;
        crc_n   = crc;
`endif
        case (state)
            IDLE: begin
                if (s_valid && ifg_ok) begin
                    txd_n  = 8'h55;
                    txen_n = 1'b1;
                    seq_n  = 8'd1;
`ifdef GMII_TX_CRC_EN
                    byte_n = 16'd0;
                    crc_n  = 32'hFFFFFFFF;
`endif
                end
            end
            PRE: begin
                txd_n  = 8'h55;
                txen_n = 1'b1;
                seq_n  = seq_cnt + 8'd1;
            end
            SFD: begin
                txd_n  = 8'hD5;
                txen_n = 1'b1;
            end
            DATA: begin
                txen_n = 1'b1;
                seq_n  = 8'd0;
                ifg_n  = '0;
                if (s_valid) begin
                    txd_n   = s_data;
                    txerr_n = s_err;
`ifdef GMII_TX_CRC_EN
                    byte_n  = byte_inc;
                    crc_n   = crc_step(crc, s_data);
`endif
                end else begin
                    // Source ran dry mid-frame: poison the byte and abort.
                    txerr_n = 1'b1;
                    urun_n  = 1'b1;
                end
            end
`ifdef GMII_TX_CRC_EN
            PAD: begin
                txen_n = 1'b1;
                byte_n = byte_inc;
                crc_n  = crc_step(crc, 8'h00);
            end
            FCS: begin
                txd_n  = fcs[{seq_cnt[1:0], 3'b000} +: 8];
                txen_n = 1'b1;
                seq_n  = seq_cnt + 8'd1;
            end
`endif
            IFG: ifg_n = ifg_cnt + 1'b1;
            default: ;
        endcase
    end

    // Registered GMII outputs and counters, held while ClkEN is low.
    always_ff @(posedge TxClk) begin
        if (!rst) begin
            TxD      <= 8'h00;
            TxEn     <= 1'b0;
            TxErr    <= 1'b0;
            underrun <= 1'b0;
            seq_cnt  <= 8'd0;
            ifg_cnt  <= IFG_N;
`ifdef GMII_TX_CRC_EN
            byte_cnt <= 16'd0;
            crc      <= 32'hFFFFFFFF;
`endif
        end else if (ClkEN) begin
            TxD      <= txd_n;
            TxEn     <= txen_n;
            TxErr    <= txerr_n;
            underrun <= urun_n;
            seq_cnt  <= seq_n;
            ifg_cnt  <= ifg_n;
`ifdef GMII_TX_CRC_EN
            byte_cnt <= byte_n;
            crc      <= crc_n;
`endif
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer (default parameters).
// Expected frame layout adapts when GMII_TX_CRC_EN is defined.
module tb_gmii_tx_framer;

    logic       TxClk = 1'b0;
    logic       rst = 1'b0;
    logic       ClkEN = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_err = 1'b0;
    logic       s_ready, TxEn, TxErr, tx_busy, underrun;
    logic [7:0] TxD;

    gmii_tx_framer dut (
        .TxClk(TxClk), .rst(rst), .ClkEN(ClkEN),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_err(s_err),
        .s_ready(s_ready), .TxD(TxD), .TxEn(TxEn), .TxErr(TxErr),
        .tx_busy(tx_busy), .underrun(underrun)
    );

    always #5 TxClk = ~TxClk;

`ifdef GMII_TX_CRC_EN
    localparam int LEN1 = 72;   // 8 + 60 + 4
    localparam int LEN2 = 72;
    localparam int LEN3 = 144;
    localparam int LEN6 = 72;
`else
    localparam int LEN1 = 17;   // 8 + 9
    localparam int LEN2 = 18;   // 8 + 10
    localparam int LEN3 = 27;   // (8 + 5) + (8 + 6)
    localparam int LEN6 = 16;   // 8 + 8
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] pay[$];
    bit         lastq[$];
    bit         errq[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         gaps[$];
    int en_hi, first_en, err_cnt, err_pos, ur_cnt, ur_pos, tail;
    int hold_bad, rdy_bad, rdy_seen, timed_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic clear_src();
        pay.delete(); lastq.delete(); errq.delete(); exp_q.delete();
    endtask

    task automatic add_frame(input logic [7:0] base, input logic [7:0] stp, input int n, input bit err_last);
        for (int i = 0; i < n; i++) begin
            pay.push_back(base + 8'(i) * stp);
            lastq.push_back(i == n - 1);
            errq.push_back((i == n - 1) && err_last);
        end
    endtask

    // Append the expected on-wire bytes of payload pay[lo +: n].
    task automatic mk_exp(input int lo, input int n);
        logic [7:0] frm[$];
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) frm.push_back(pay[lo + i]);
`ifdef GMII_TX_CRC_EN
        begin
            logic [31:0] c;
            while (frm.size() < 60) frm.push_back(8'h00);
            c = 32'hFFFFFFFF;
            foreach (frm[i]) c = crc32(c, frm[i]);
            c = ~c;
            foreach (frm[i]) exp_q.push_back(frm[i]);
            for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
        end
`else
        foreach (frm[i]) exp_q.push_back(frm[i]);
`endif
    endtask

    task automatic cmp_bytes(input string tag, input int n);
        for (int i = 0; i < n && i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
    endtask

    // Drive pay[] as a source, record every TxEn byte, stop once idle again.
    task automatic send(input int drop_at, input int div, input int rst_at);
        int idx, ph, low;
        bit seen, acc, en;
        logic [7:0] held;
        idx = 0; ph = 0; low = 0; seen = 0; held = 8'h00;
        got.delete(); gaps.delete();
        en_hi = 0; first_en = -1; err_cnt = 0; err_pos = -1; ur_cnt = 0; ur_pos = -1;
        tail = -1; hold_bad = 0; rdy_bad = 0; rdy_seen = 0; timed_out = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            en = (ph == 0);
            ph = (ph + 1 == div) ? 0 : ph + 1;
            ClkEN = en;
            if (idx < pay.size() && idx != drop_at) begin
                s_valid = 1'b1; s_data = pay[idx]; s_last = lastq[idx]; s_err = errq[idx];
            end else begin
                s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_err = 1'b0;
            end
            if (idx == rst_at) rst = 1'b0;
            #1;
            acc = s_valid && s_ready;
            if (s_ready && !en) rdy_bad++;
            if (s_ready) rdy_seen++;
            @(posedge TxClk); #1;
            if (!rst) begin
                chk("rst_txen", {31'h0, TxEn}, 32'h0);
                chk("rst_ready", {31'h0, s_ready}, 32'h0);
                chk("rst_busy", {31'h0, tx_busy}, 32'h0);
                chk("rst_txerr", {31'h0, TxErr}, 32'h0);
                rst = 1'b1;
                return;
            end
            if (acc) idx++;
            if (TxEn) begin
                if (en) begin
                    got.push_back(TxD);
                    en_hi++;
                    held = TxD;
                    if (first_en < 0) first_en = cyc;
                    if (TxErr) begin err_cnt++; err_pos = got.size() - 1; end
                end else if (TxD !== held) begin
                    hold_bad++;
                end
                if (seen && low > 0) gaps.push_back(low);
                seen = 1; low = 0;
            end else if (seen) begin
                if (en) low++;
                if (!tx_busy && (idx == pay.size() || idx == drop_at)) begin
                    tail = low;
                    return;
                end
            end
            if (en && underrun) begin
                ur_cnt++;
                ur_pos = TxEn ? got.size() - 1 : -2;
            end
        end
        timed_out = 1;
    endtask

    initial begin
        // Reset state
        rst = 1'b0; ClkEN = 1'b1;
        repeat (3) @(posedge TxClk);
        #1;
        chk("reset_txd", {24'h0, TxD}, 32'h0);
        chk("reset_txen", {31'h0, TxEn}, 32'h0);
        chk("reset_txerr", {31'h0, TxErr}, 32'h0);
        chk("reset_underrun", {31'h0, underrun}, 32'h0);
        chk("reset_busy", {31'h0, tx_busy}, 32'h0);
        chk("reset_ready", {31'h0, s_ready}, 32'h0);
        rst = 1'b1;
        @(posedge TxClk); #1;
        chk("idle_busy", {31'h0, tx_busy}, 32'h0);
        chk("idle_txen", {31'h0, TxEn}, 32'h0);

        // 1: "123456789"
        clear_src(); add_frame(8'h31, 8'h01, 9, 1'b0); mk_exp(0, 9);
        send(-1, 1, -1);
        chk("t1_done", timed_out, 0);
        chk("t1_len", got.size(), LEN1);
        chk("t1_enhi", en_hi, LEN1);
        chk("t1_first_latency", first_en, 0);
        if (got.size() > 16) begin
            chk("t1_sfd", {24'h0, got[7]}, 32'hD5);
            chk("t1_d0", {24'h0, got[8]}, 32'h31);
            chk("t1_d8", {24'h0, got[16]}, 32'h39);
        end
        cmp_bytes("t1", LEN1);
        chk("t1_errs", err_cnt, 0);
        chk("t1_urun", ur_cnt, 0);
        chk("t1_tail", tail, 12);

        // 2: 10-byte payload
        clear_src(); add_frame(8'hA0, 8'h01, 10, 1'b0); mk_exp(0, 10);
        send(-1, 1, -1);
        chk("t2_done", timed_out, 0);
        chk("t2_len", got.size(), LEN2);
        chk("t2_enhi", en_hi, LEN2);
        cmp_bytes("t2", LEN2);
        chk("t2_tail", tail, 12);

        // 3: back-to-back, s_valid held; first frame ends on an errored last byte
        clear_src(); add_frame(8'h10, 8'h01, 5, 1'b1); add_frame(8'h20, 8'h01, 6, 1'b0);
        mk_exp(0, 5); mk_exp(5, 6);
        send(-1, 1, -1);
        chk("t3_done", timed_out, 0);
        chk("t3_len", got.size(), LEN3);
        chk("t3_ngaps", gaps.size(), 1);
        if (gaps.size() > 0) chk("t3_gap", gaps[0], 12);
        chk("t3_errs", err_cnt, 1);
        chk("t3_errpos", err_pos, 12);
        if (got.size() > 12) chk("t3_errbyte", {24'h0, got[12]}, 32'h14);
        cmp_bytes("t3", LEN3);

        // 4: underrun at payload byte 20
        clear_src(); add_frame(8'h00, 8'h07, 30, 1'b0); mk_exp(0, 30);
        send(20, 1, -1);
        chk("t4_done", timed_out, 0);
        chk("t4_len", got.size(), 29);
        cmp_bytes("t4", 28);
        if (got.size() > 28) chk("t4_errbyte", {24'h0, got[28]}, 32'h00);
        chk("t4_errs", err_cnt, 1);
        chk("t4_errpos", err_pos, 28);
        chk("t4_urun", ur_cnt, 1);
        chk("t4_urpos", ur_pos, 28);
        chk("t4_tail", tail, 12);

        // 5: ClkEN 1-in-10, same payload as 2
        clear_src(); add_frame(8'hA0, 8'h01, 10, 1'b0); mk_exp(0, 10);
        send(-1, 10, -1);
        chk("t5_done", timed_out, 0);
        chk("t5_len", got.size(), LEN2);
        cmp_bytes("t5", LEN2);
        chk("t5_hold", hold_bad, 0);
        chk("t5_ready_gate", rdy_bad, 0);
        chk("t5_ready_count", rdy_seen, 10);
        chk("t5_tail", tail, 12);

        // 6: reset during payload byte 5, then an immediate new frame
        clear_src(); add_frame(8'h40, 8'h01, 20, 1'b0);
        send(-1, 1, 5);
        chk("t6_len_before_rst", got.size(), 13);
        clear_src(); add_frame(8'h60, 8'h01, 8, 1'b0); mk_exp(0, 8);
        send(-1, 1, -1);
        chk("t6_done", timed_out, 0);
        chk("t6_first_latency", first_en, 0);
        chk("t6_len", got.size(), LEN6);
        cmp_bytes("t6", LEN6);
        chk("t6_tail", tail, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
